// File: rtl/scene_pkg.sv
// scene_pkg: shared scene codes, default widths and fade FSM states for scene_compositor
package scene_pkg;
  localparam int SEL_W = 4;
  localparam int ADDR_W = 17;
  localparam int RGB_W = 12;
  localparam int LEVEL_MAX = 16;
  localparam logic [SEL_W-1:0] START = 4'd1;
  localparam logic [SEL_W-1:0] CHOOSE = 4'd2;
  localparam logic [SEL_W-1:0] FIGHT = 4'd3;
  localparam logic [SEL_W-1:0] WIN = 4'd4;
  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} fade_state_t;
endpackage

// File: rtl/rgb_scale.sv
// rgb_scale: combinational per-component brightness scaling, c*level/LEVEL_MAX
module rgb_scale
  import scene_pkg::*;
#(
  parameter int RGB_W = scene_pkg::RGB_W
) (
  input logic [RGB_W-1:0] rgb,
  input logic [4:0] level,
  output logic [RGB_W-1:0] scaled
);
  localparam int C = RGB_W / 3;
  localparam int P = C + 5;
  for (genvar i = 0; i < 3; i++) begin : g_comp
    assign scaled[i*C +: C] = C'((P'(rgb[i*C +: C]) * P'(level)) >> $clog2(LEVEL_MAX));
  end
endmodule

// File: rtl/scene_compositor.sv
// scene_compositor: scene channel mux with registered blank-aware RGB; SCENE_COMPOSITOR_FADE_EN adds the frame-timed fade FSM
module scene_compositor #(
  parameter int N_SCENES = 4,
  parameter int SEL_W = scene_pkg::SEL_W,
  parameter int ADDR_W = scene_pkg::ADDR_W,
  parameter int RGB_W = scene_pkg::RGB_W,
  parameter int FRAMES_PER_STEP = 2
) (
  input logic clk,
  input logic reset,
  input logic [SEL_W-1:0] scene_state,
  input logic frame_tick,
  input logic valid,
  input logic [N_SCENES*ADDR_W-1:0] addr_in,
  input logic [N_SCENES*RGB_W-1:0] rgb_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [SEL_W-1:0] shown_scene,
  output logic busy
);
  import scene_pkg::*;
  localparam logic [4:0] LVL_MAX = 5'(LEVEL_MAX);
  fade_state_t state, state_nx;
  logic [4:0] level;
  logic [RGB_W-1:0] rgb_sel, rgb_scaled;
  logic mismatch;
  assign mismatch = scene_state != shown_scene;
  assign busy = state != SHOW;
  always_comb begin
    addr_out = '0;
    rgb_sel = '0;
    for (int i = 0; i < N_SCENES; i++)
      if (shown_scene == SEL_W'(i + 1)) begin
        addr_out = addr_in[i*ADDR_W +: ADDR_W];
        rgb_sel = rgb_in[i*RGB_W +: RGB_W];
      end
  end
  rgb_scale #(.RGB_W(RGB_W)) u_scale (.rgb(rgb_sel), .level(level), .scaled(rgb_scaled));
`ifdef SCENE_COMPOSITOR_FADE_EN
  logic [7:0] fcnt, fcnt_nx;
  logic [4:0] level_nx;
  logic step, fading;
  assign step = frame_tick && fcnt == 8'(FRAMES_PER_STEP - 1);
  assign fading = state == FADE_OUT || (state == FADE_IN && !mismatch);
  assign fcnt_nx = !fading || step ? '0 : fcnt + 8'(frame_tick);
  always_comb begin
    state_nx = state;
    level_nx = level;
    case (state)
      SHOW: begin
        level_nx = LVL_MAX;
        state_nx = mismatch ? FADE_OUT : SHOW;
      end
      FADE_OUT: begin
        level_nx = step && level != 5'd0 ? level - 5'd1 : level;
        state_nx = level == 5'd0 || (step && level == 5'd1) ? SWAP : FADE_OUT;
      end
      SWAP: state_nx = FADE_IN;
      FADE_IN: begin
        level_nx = !mismatch && step ? level + 5'd1 : level;
        state_nx = mismatch ? FADE_OUT : step && level == LVL_MAX - 5'd1 ? SHOW : FADE_IN;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      level <= LVL_MAX;
      fcnt <= '0;
    end else begin
      level <= level_nx;
      fcnt <= fcnt_nx;
    end
`else
  logic unused_tick;
  assign unused_tick = frame_tick ^ (FRAMES_PER_STEP > 0);
  assign level = LVL_MAX;
  assign state_nx = state == SHOW && mismatch ? SWAP : SHOW;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= SHOW;
      shown_scene <= '0;
      rgb_out <= '0;
    end else begin
      state <= state_nx;
      if (state == SWAP) shown_scene <= scene_state;
      rgb_out <= valid ? rgb_scaled : '0;
    end
endmodule

// File: tb/tb_scene_compositor.sv
// tb_scene_compositor: scoreboard bench; expectations queued with target cycle, checked by a negedge monitor
module tb_scene_compositor;
  localparam int RGB = 0;
  localparam int ADDR = 1;
  localparam int SHOWN = 2;
  localparam int BUSY = 3;
  logic clk = 1'b0;
  logic reset, frame_tick, valid;
  logic [3:0] scene_state;
  logic [4*17-1:0] addr_in;
  logic [4*12-1:0] rgb_in;
  logic [16:0] addr_out;
  logic [11:0] rgb_out;
  logic [3:0] shown_scene;
  logic busy;
  typedef struct {
    int cyc;
    int sig;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  scene_compositor #(.N_SCENES(4), .SEL_W(4), .ADDR_W(17), .RGB_W(12), .FRAMES_PER_STEP(1)) dut (
    .clk(clk),
    .reset(reset),
    .scene_state(scene_state),
    .frame_tick(frame_tick),
    .valid(valid),
    .addr_in(addr_in),
    .rgb_in(rgb_in),
    .addr_out(addr_out),
    .rgb_out(rgb_out),
    .shown_scene(shown_scene),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sig);
    return sig == RGB ? 32'(rgb_out) : sig == ADDR ? 32'(addr_out) : sig == SHOWN ? 32'(shown_scene) : 32'(busy);
  endfunction

  task automatic chk(input int dt, input int sig, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + dt;
    e.sig = sig;
    e.exp = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        total++;
        if (actual(q[i].sig) !== q[i].exp) begin
          bad++;
          $display("FAIL %s: actual=%h required=%h (cycle %0d)", q[i].name, actual(q[i].sig), q[i].exp, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid = 1'b1;
    frame_tick = 1'b0;
    scene_state = 4'd0;
    addr_in = {17'h10044, 17'h00033, 17'h00022, 17'h00011};
    rgb_in = {12'h5A7, 12'hABC, 12'h123, 12'hF84};
    step();
    step();
    chk(0, RGB, 0, "rst_rgb");
    chk(0, ADDR, 0, "rst_addr");
    chk(0, SHOWN, 0, "rst_shown");
    chk(0, BUSY, 0, "rst_busy");
    step();
`ifdef SCENE_COMPOSITOR_FADE_EN
    reset = 1'b0;
    scene_state = 4'd1;
    step();
    chk(0, BUSY, 1, "fo_busy");
    repeat (16) tick();
    chk(0, SHOWN, 1, "swap1_shown");
    chk(0, ADDR, 32'h11, "swap1_addr");
    chk(0, BUSY, 1, "fi_busy");
    repeat (16) tick();
    chk(0, BUSY, 0, "fi_done_busy");
    chk(0, RGB, 32'hF84, "fi_done_rgb");
    valid = 1'b0;
    chk(1, RGB, 0, "blank");
    step();
    valid = 1'b1;
    chk(1, RGB, 32'hF84, "unblank");
    step();
    scene_state = 4'd3;
    step();
    repeat (8) tick();
    chk(0, RGB, 32'h742, "half_rgb");
    chk(0, BUSY, 1, "half_busy");
    repeat (7) tick();
    chk(0, ADDR, 32'h11, "addr_hold");
    tick();
    chk(0, SHOWN, 3, "swap3_shown");
    chk(0, ADDR, 32'h33, "swap3_addr");
    repeat (10) tick();
    chk(0, RGB, 32'h667, "lvl10_rgb");
    scene_state = 4'd2;
    step();
    chk(0, BUSY, 1, "refade_busy");
    repeat (9) tick();
    chk(0, SHOWN, 3, "refade_hold");
    tick();
    chk(0, SHOWN, 2, "swap2_shown");
    repeat (16) tick();
    chk(0, BUSY, 0, "scene2_busy");
    chk(0, RGB, 32'h123, "scene2_rgb");
    scene_state = 4'd7;
    step();
    repeat (16) tick();
    chk(0, SHOWN, 7, "inv_shown");
    chk(0, ADDR, 0, "inv_addr");
    repeat (8) tick();
    chk(0, RGB, 0, "inv_rgb");
    chk(0, BUSY, 1, "inv_busy");
    repeat (8) tick();
    chk(0, BUSY, 0, "inv_done");
    scene_state = 4'd1;
    step();
    repeat (5) tick();
    chk(0, BUSY, 1, "mid_busy");
    reset = 1'b1;
    chk(1, BUSY, 0, "mrst_busy");
    chk(1, SHOWN, 0, "mrst_shown");
    chk(1, RGB, 0, "mrst_rgb");
    chk(1, ADDR, 0, "mrst_addr");
    step();
    reset = 1'b0;
    scene_state = 4'd0;
    step();
    chk(0, BUSY, 0, "post_rst_busy");
`else
    reset = 1'b0;
    scene_state = 4'd1;
    chk(1, BUSY, 1, "swap1_busy");
    chk(1, SHOWN, 0, "swap1_pre");
    chk(1, RGB, 0, "none_rgb");
    chk(2, BUSY, 0, "swap1_done");
    chk(2, SHOWN, 1, "swap1_shown");
    chk(2, ADDR, 32'h11, "swap1_addr");
    chk(3, RGB, 32'hF84, "ch0_rgb");
    repeat (3) step();
    valid = 1'b0;
    chk(1, RGB, 0, "blank");
    step();
    valid = 1'b1;
    frame_tick = 1'b1;
    chk(1, RGB, 32'hF84, "unblank");
    chk(1, BUSY, 0, "tick_ignored");
    step();
    frame_tick = 1'b0;
    step();
    scene_state = 4'd4;
    chk(1, BUSY, 1, "swap4_busy");
    chk(1, ADDR, 32'h11, "addr_hold");
    chk(2, BUSY, 0, "swap4_done");
    chk(2, ADDR, 32'h10044, "swap4_addr");
    chk(2, RGB, 32'hF84, "old_rgb");
    chk(3, RGB, 32'h5A7, "ch3_rgb");
    repeat (3) step();
    scene_state = 4'd7;
    chk(2, SHOWN, 7, "inv_shown");
    chk(2, ADDR, 0, "inv_addr");
    chk(3, RGB, 0, "inv_rgb");
    repeat (3) step();
    scene_state = 4'd2;
    repeat (3) step();
    chk(0, RGB, 32'h123, "ch1_rgb");
    rgb_in[23:12] = 12'hFFF;
    chk(1, RGB, 32'hFFF, "ch1_new_rgb");
    step();
    scene_state = 4'd3;
    step();
    chk(0, BUSY, 1, "swap3_busy");
    reset = 1'b1;
    chk(1, BUSY, 0, "mrst_busy");
    chk(1, SHOWN, 0, "mrst_shown");
    chk(1, RGB, 0, "mrst_rgb");
    step();
    reset = 1'b0;
    step();
    scene_state = 4'd2;
    chk(1, SHOWN, 2, "latest_shown");
    chk(1, ADDR, 32'h22, "latest_addr");
    chk(1, BUSY, 0, "latest_busy");
    step();
    step();
    chk(0, BUSY, 0, "no_retrigger");
`endif
    repeat (3) step();
    if (q.size() != 0) begin
      total += q.size();
      bad += q.size();
      $display("FAIL unchecked: actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
